// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and constants for the mac_tile array sequencer.
//   state_e    - sequencer phases
//   INST_*     - 2-bit west-edge instruction encodings
//   drain_len  - cycles needed to flush the row/column skew and psums
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;
    localparam logic [1:0] INST_OS   = 2'b11;

    localparam int DEF_ROW = 8;
    localparam int DEF_COL = 8;

    function automatic int drain_len(input int row, input int col);
        return row + col - 1;
    endfunction

    localparam int DRAIN_LEN = drain_len(DEF_ROW, DEF_COL);

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// skew_line: fixed-depth delay line used to skew per-lane signals.
//   clk   - clock
//   reset - asynchronous active-low clear (all stages to 0)
//   din   - undelayed lane-0 value
//   taps  - taps[k*WIDTH +: WIDTH] is din delayed by k+1 cycles
// DEPTH must be at least 1 (array dimension of 2 or more).
module skew_line #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH*DEPTH-1:0] taps
);

    logic [WIDTH*DEPTH-1:0] chain_q;
    logic [WIDTH*DEPTH-1:0] chain_d;

    // Lowest slice is the newest sample; every cycle the chain moves up one slot.
    generate
        if (DEPTH == 1) begin : g_single
            always_comb chain_d = din;
        end else begin : g_multi
            always_comb chain_d = {chain_q[WIDTH*(DEPTH-1)-1:0], din};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) chain_q <= '0;
        else        chain_q <= chain_d;
    end

    assign taps = chain_q;

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: run sequencer for the mac_tile systolic array.
//   start/mode/ld_len/ex_len - run request, parameters latched on acceptance in IDLE
//   abort                    - ends LOAD or EXEC early, run still drains and reports done
//   array_reset              - one-cycle reset pulse to all tiles
//   inst_w                   - per-row instruction, row r = lane-0 delayed r cycles
//   l0_rd / n_rd             - skewed west / north feeder read enables
//   busy / done              - activity flag and end-of-run pulse
// Every output decodes only the state and skew registers.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int CNT_BW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [CNT_BW-1:0] ld_len,
    input  logic [CNT_BW-1:0] ex_len,
    output logic              array_reset,
    output logic [2*ROW-1:0]  inst_w,
    output logic [ROW-1:0]    l0_rd,
    output logic [COL-1:0]    n_rd,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_BW-1:0] DRAIN_LAST = CNT_BW'(drain_len(ROW, COL) - 1);

    state_e            state_q, state_d;
    logic [CNT_BW-1:0] cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [CNT_BW-1:0] ld_q, ld_d;
    logic [CNT_BW-1:0] ex_q, ex_d;

    logic [1:0]            lane0_inst;
    logic                  lane0_nrd;
    logic [2*(ROW-1)-1:0]  row_taps;
    logic [COL-2:0]        col_taps;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ld_q    <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ld_q    <= ld_d;
            ex_q    <= ex_d;
        end
    end

    // Next-state logic. Counters are preloaded with length-1 on phase entry,
    // so a phase ends on the cycle its counter reads zero; zero lengths never
    // enter their phase at all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ld_d    = ld_q;
        ex_d    = ex_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RST;
                    mode_d  = mode;
                    ld_d    = ld_len;
                    ex_d    = ex_len;
                end
            end
            ST_RST: begin
                if (mode_q && ld_q != '0) begin
                    state_d = ST_LOAD;
                    cnt_d   = ld_q - 1'b1;
                end else if (ex_q != '0) begin
                    state_d = ST_EXEC;
                    cnt_d   = ex_q - 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LAST;
                end
            end
            ST_LOAD: begin
                if (!abort && cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!abort && ex_q != '0) begin
                    state_d = ST_EXEC;
                    cnt_d   = ex_q - 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LAST;
                end
            end
            ST_EXEC: begin
                if (abort || cnt_q == '0) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        lane0_inst  = INST_NOP;
        lane0_nrd   = 1'b0;
        array_reset = (state_q == ST_RST);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        case (state_q)
            ST_LOAD: lane0_inst = INST_LOAD;
            ST_EXEC: begin
                lane0_inst = mode_q ? INST_EXEC : INST_OS;
                lane0_nrd  = !mode_q;
            end
            default: lane0_inst = INST_NOP;
        endcase
    end

    skew_line #(.WIDTH(2), .DEPTH(ROW-1)) u_row_skew (
        .clk   (clk),
        .reset (reset),
        .din   (lane0_inst),
        .taps  (row_taps)
    );

    skew_line #(.WIDTH(1), .DEPTH(COL-1)) u_col_skew (
        .clk   (clk),
        .reset (reset),
        .din   (lane0_nrd),
        .taps  (col_taps)
    );

    assign inst_w = {row_taps, lane0_inst};
    assign n_rd   = {col_taps, lane0_nrd};

    generate
        for (genvar gi = 0; gi < ROW; gi++) begin : g_l0_rd
            assign l0_rd[gi] = (inst_w[2*gi +: 2] != INST_NOP);
        end
    endgenerate

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

    localparam int ROW    = 4;
    localparam int COL    = 4;
    localparam int CNT_BW = 8;
    localparam int MAXC   = 128;
    localparam int DLEN   = ROW + COL - 1;

    typedef struct packed {
        logic             ar;
        logic             bz;
        logic             dn;
        logic [2*ROW-1:0] inst;
        logic [ROW-1:0]   l0;
        logic [COL-1:0]   nrd;
    } snap_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              mode = 1'b0;
    logic [CNT_BW-1:0] ld_len = '0;
    logic [CNT_BW-1:0] ex_len = '0;
    logic              array_reset;
    logic [2*ROW-1:0]  inst_w;
    logic [ROW-1:0]    l0_rd;
    logic [COL-1:0]    n_rd;
    logic              busy;
    logic              done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-cycle stimulus vectors and recorded/expected snapshots.
    logic              st_v [MAXC];
    logic              ab_v [MAXC];
    logic              md_v [MAXC];
    logic [CNT_BW-1:0] ld_v [MAXC];
    logic [CNT_BW-1:0] ex_v [MAXC];
    snap_t             obs  [MAXC];
    snap_t             expv [MAXC];

    systolic_ctrl #(.ROW(ROW), .COL(COL), .CNT_BW(CNT_BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .ld_len      (ld_len),
        .ex_len      (ex_len),
        .array_reset (array_reset),
        .inst_w      (inst_w),
        .l0_rd       (l0_rd),
        .n_rd        (n_rd),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic snap_t now_snap();
        return {array_reset, busy, done, inst_w, l0_rd, n_rd};
    endfunction

    // Inputs default to junk so latching at start is exercised.
    task automatic clear_vecs();
        for (int t = 0; t < MAXC; t++) begin
            st_v[t] = 1'b0;
            ab_v[t] = 1'b0;
            md_v[t] = 1'($urandom);
            ld_v[t] = CNT_BW'($urandom);
            ex_v[t] = CNT_BW'($urandom);
        end
    endtask

    task automatic set_params(input int from, input int to, input logic md,
                              input int ld, input int ex);
        for (int t = from; t <= to; t++) begin
            md_v[t] = md;
            ld_v[t] = CNT_BW'(ld);
            ex_v[t] = CNT_BW'(ex);
        end
    endtask

    // Applies the vectors: at the negedge of cycle t the outputs of cycle t
    // are recorded and the inputs seen by the edge ending cycle t are set.
    task automatic drive_run(input int n);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            obs[t] = now_snap();
            start  = st_v[t];
            abort  = ab_v[t];
            mode   = md_v[t];
            ld_len = ld_v[t];
            ex_len = ex_v[t];
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Behavioural reference: walks the start vector, lays out each accepted
    // run as phase intervals, then derives every lane from the lane-0 timeline.
    task automatic build_model(input int n);
        logic [1:0] lane [MAXC];
        logic       nex  [MAXC];
        logic       ar   [MAXC];
        logic       bz   [MAXC];
        logic       dn   [MAXC];
        int next_free, s, l, e, ph_end, d_at;
        for (int t = 0; t < MAXC; t++) begin
            lane[t] = 2'b00; nex[t] = 1'b0; ar[t] = 1'b0; bz[t] = 1'b0; dn[t] = 1'b0;
        end
        next_free = 0;
        for (int t = 0; t < n; t++) begin
            if (t >= next_free && st_v[t]) begin
                s = t;
                l = md_v[s] ? int'(ld_v[s]) : 0;
                e = int'(ex_v[s]);
                ph_end = s + 1 + l + e;
                for (int a = s + 2; a <= ph_end && a < n; a++) begin
                    if (ab_v[a]) begin
                        ph_end = a;
                        break;
                    end
                end
                for (int u = s + 2; u <= ph_end && u < MAXC; u++) begin
                    if (u <= s + 1 + l) begin
                        lane[u] = 2'b01;
                    end else begin
                        lane[u] = md_v[s] ? 2'b10 : 2'b11;
                        nex[u]  = !md_v[s];
                    end
                end
                d_at = ph_end + 1 + DLEN;
                if (s + 1 < MAXC) ar[s+1] = 1'b1;
                for (int u = s + 1; u <= d_at && u < MAXC; u++) bz[u] = 1'b1;
                if (d_at < MAXC) dn[d_at] = 1'b1;
                next_free = d_at + 1;
            end
        end
        for (int t = 0; t < n; t++) begin
            snap_t x;
            x    = '0;
            x.ar = ar[t];
            x.bz = bz[t];
            x.dn = dn[t];
            for (int r = 0; r < ROW; r++) begin
                if (t - r >= 0) x.inst[2*r +: 2] = lane[t-r];
                x.l0[r] = (x.inst[2*r +: 2] != 2'b00);
            end
            for (int c = 0; c < COL; c++) begin
                if (t - c >= 0) x.nrd[c] = nex[t-c];
            end
            expv[t] = x;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (now_snap() !== snap_t'(0)) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", now_snap(), snap_t'(0));
        end
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (now_snap() !== snap_t'(0)) begin
                n_fail++;
                $display("FAIL reset_hold: got %h want %h", now_snap(), snap_t'(0));
            end
        end
        reset = 1'b1;
        $display("reset: outputs held at zero");
    endtask

    task automatic test_ws();
        int n = 24;
        clear_vecs();
        st_v[0] = 1'b1;
        set_params(0, 0, 1'b1, 4, 6);
        drive_run(n);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs[t] !== expv[t]) begin
                n_fail++;
                $display("FAIL ws_run cycle %0d: got %h want %h", t, obs[t], expv[t]);
            end
        end
        n_cmp++;
        if (obs[1].ar !== 1'b1 || obs[19].dn !== 1'b1 || obs[18].dn !== 1'b0) begin
            n_fail++;
            $display("FAIL ws_points: ar1=%b dn18=%b dn19=%b want 1 0 1", obs[1].ar, obs[18].dn, obs[19].dn);
        end
        n_cmp++;
        if (obs[5].inst[1:0] !== 2'b01 || obs[6].inst[1:0] !== 2'b10 ||
            obs[8].inst[7:6] !== 2'b01 || obs[14].inst[7:6] !== 2'b10 ||
            obs[15].inst[7:6] !== 2'b00) begin
            n_fail++;
            $display("FAIL ws_skew: got %b %b %b %b %b want 01 10 01 10 00", obs[5].inst[1:0],
                     obs[6].inst[1:0], obs[8].inst[7:6], obs[14].inst[7:6], obs[15].inst[7:6]);
        end
        $display("ws_run: mode=1 ld=4 ex=6 checked %0d cycles", n);
    endtask

    task automatic test_os();
        int n = 20;
        clear_vecs();
        st_v[0] = 1'b1;
        set_params(0, 0, 1'b0, 4, 5);
        drive_run(n);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs[t] !== expv[t]) begin
                n_fail++;
                $display("FAIL os_run cycle %0d: got %h want %h", t, obs[t], expv[t]);
            end
        end
        n_cmp++;
        if (obs[2].inst[1:0] !== 2'b11 || obs[5].nrd[3] !== 1'b1 || obs[9].nrd[3] !== 1'b1 ||
            obs[10].nrd[3] !== 1'b0 || obs[14].dn !== 1'b1) begin
            n_fail++;
            $display("FAIL os_points: inst2=%b nrd3@5=%b @9=%b @10=%b dn14=%b want 11 1 1 0 1",
                     obs[2].inst[1:0], obs[5].nrd[3], obs[9].nrd[3], obs[10].nrd[3], obs[14].dn);
        end
        $display("os_run: mode=0 ld=4 ex=5 checked %0d cycles", n);
    endtask

    task automatic test_zero_len();
        int n = 14;
        clear_vecs();
        st_v[0] = 1'b1;
        set_params(0, 0, 1'b1, 0, 0);
        drive_run(n);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs[t] !== expv[t]) begin
                n_fail++;
                $display("FAIL zero_len cycle %0d: got %h want %h", t, obs[t], expv[t]);
            end
        end
        n_cmp++;
        if (obs[9].dn !== 1'b1 || obs[8].bz !== 1'b1 || obs[10].bz !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_points: dn9=%b bz8=%b bz10=%b want 1 1 0", obs[9].dn, obs[8].bz, obs[10].bz);
        end
        $display("zero_len: mode=1 ld=0 ex=0 checked %0d cycles", n);
    endtask

    task automatic test_start_hold();
        int n = 45;
        clear_vecs();
        set_params(0, n - 1, 1'b1, 4, 6);
        for (int t = 0; t <= 21; t++) st_v[t] = 1'b1;
        drive_run(n);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs[t] !== expv[t]) begin
                n_fail++;
                $display("FAIL start_hold cycle %0d: got %h want %h", t, obs[t], expv[t]);
            end
        end
        n_cmp++;
        if (obs[21].ar !== 1'b1 || obs[39].dn !== 1'b1 || obs[41].bz !== 1'b0) begin
            n_fail++;
            $display("FAIL start_hold_points: ar21=%b dn39=%b bz41=%b want 1 1 0", obs[21].ar, obs[39].dn, obs[41].bz);
        end
        $display("start_hold: two runs checked over %0d cycles", n);
    endtask

    task automatic test_start_in_exec();
        int n = 24;
        clear_vecs();
        st_v[0] = 1'b1;
        st_v[8] = 1'b1;
        set_params(0, 0, 1'b1, 4, 6);
        drive_run(n);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs[t] !== expv[t]) begin
                n_fail++;
                $display("FAIL start_in_exec cycle %0d: got %h want %h", t, obs[t], expv[t]);
            end
        end
        $display("start_in_exec: pulse at cycle 8 checked %0d cycles", n);
    endtask

    task automatic test_abort();
        int n = 18;
        clear_vecs();
        st_v[0] = 1'b1;
        set_params(0, 0, 1'b1, 10, 3);
        ab_v[1] = 1'b1;
        ab_v[4] = 1'b1;
        ab_v[8] = 1'b1;
        drive_run(n);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs[t] !== expv[t]) begin
                n_fail++;
                $display("FAIL abort cycle %0d: got %h want %h", t, obs[t], expv[t]);
            end
        end
        n_cmp++;
        if (obs[12].dn !== 1'b1 || obs[7].inst[7:6] !== 2'b01 || obs[8].inst[7:6] !== 2'b00 ||
            obs[5].inst[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_points: dn12=%b row3@7=%b row3@8=%b lane0@5=%b want 1 01 00 00",
                     obs[12].dn, obs[7].inst[7:6], obs[8].inst[7:6], obs[5].inst[1:0]);
        end
        $display("abort: abort at cycle 4 of ld=10 run checked %0d cycles", n);
    endtask

    task automatic test_back_to_back();
        int n = 40;
        clear_vecs();
        st_v[0]  = 1'b1;
        st_v[11] = 1'b1;
        st_v[12] = 1'b1;
        set_params(0, 0, 1'b0, 3, 2);
        set_params(12, 12, 1'b1, 2, 3);
        drive_run(n);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs[t] !== expv[t]) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", t, obs[t], expv[t]);
            end
        end
        $display("back_to_back: OS then WS run checked %0d cycles", n);
    endtask

    task automatic test_random();
        int n = 70;
        for (int it = 0; it < 6; it++) begin
            clear_vecs();
            for (int t = 0; t < n; t++) begin
                md_v[t] = 1'($urandom);
                ld_v[t] = CNT_BW'($urandom_range(0, 9));
                ex_v[t] = CNT_BW'($urandom_range(0, 9));
                ab_v[t] = ($urandom_range(0, 15) == 0);
                st_v[t] = (t == 0) || (t < 40 && $urandom_range(0, 7) == 0);
            end
            drive_run(n);
            build_model(n);
            for (int t = 0; t < n; t++) begin
                n_cmp++;
                if (obs[t] !== expv[t]) begin
                    n_fail++;
                    $display("FAIL random%0d cycle %0d: got %h want %h", it, t, obs[t], expv[t]);
                end
            end
            $display("random%0d: mode=%0d ld=%0d ex=%0d checked %0d cycles", it, md_v[0], ld_v[0], ex_v[0], n);
        end
    endtask

    task automatic test_async_reset();
        int n = 7;
        clear_vecs();
        st_v[0] = 1'b1;
        set_params(0, 0, 1'b1, 4, 6);
        drive_run(n);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs[t] !== expv[t]) begin
                n_fail++;
                $display("FAIL async_pre cycle %0d: got %h want %h", t, obs[t], expv[t]);
            end
        end
        // Now inside cycle 7 (EXEC): drop reset between edges.
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (now_snap() !== snap_t'(0)) begin
            n_fail++;
            $display("FAIL async_clear: got %h want %h", now_snap(), snap_t'(0));
        end
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (now_snap() !== snap_t'(0)) begin
                n_fail++;
                $display("FAIL async_hold: got %h want %h", now_snap(), snap_t'(0));
            end
        end
        reset = 1'b1;
        n = 24;
        clear_vecs();
        st_v[0] = 1'b1;
        set_params(0, 0, 1'b1, 4, 6);
        drive_run(n);
        build_model(n);
        for (int t = 0; t < n; t++) begin
            n_cmp++;
            if (obs[t] !== expv[t]) begin
                n_fail++;
                $display("FAIL async_rerun cycle %0d: got %h want %h", t, obs[t], expv[t]);
            end
        end
        $display("async_reset: cleared mid-EXEC, rerun checked %0d cycles", n);
    endtask

    initial begin
        test_reset();
        test_ws();
        test_os();
        test_zero_len();
        test_start_hold();
        test_start_in_exec();
        test_abort();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
